// File: rtl/mod5_stream_sched_if.sv
// mod5_stream_sched_if
// Handshake bundle between the word requesters, the mod-5 scheduler and the
// result consumer.
//   req0_valid/req0_data/req0_ready : requester 0 word port
//   req1_valid/req1_data/req1_ready : requester 1 word port
//   res_valid/res_ready             : result handshake
//   res_id/res_residue/res_div      : result payload (source, word mod 5, divisible)
// Modport slave is the scheduler side, master is the requester/consumer side.

interface mod5_stream_sched_if #(
    parameter int W = 8
);
    logic         req0_valid;
    logic [W-1:0] req0_data;
    logic         req0_ready;
    logic         req1_valid;
    logic [W-1:0] req1_data;
    logic         req1_ready;
    logic         res_valid;
    logic         res_ready;
    logic         res_id;
    logic [2:0]   res_residue;
    logic         res_div;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, res_ready,
        output req0_ready, req1_ready, res_valid, res_id, res_residue, res_div
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, res_ready,
        input  req0_ready, req1_ready, res_valid, res_id, res_residue, res_div
    );
endinterface

// File: rtl/mod5_stream_sched.sv
// mod5_stream_sched
// Two-requester round-robin scheduler feeding a serial MSB-first mod-5
// residue tracker. One word is in flight at a time; the result is held on a
// valid/ready port until consumed.
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-high
//   clr  : synchronous flush back to IDLE (round-robin pointer kept)
//   bus  : requester and result handshakes (slave modport)
//   busy : high whenever state != IDLE
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for a requester; ready offered to the granted one
//   SHIFT | one word bit folded into the residue per cycle, W cycles
//   DONE  | result presented, held until res_ready

module mod5_stream_sched #(
    parameter int W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    mod5_stream_sched_if.slave     bus,
    output logic                   busy
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          rr_q, rr_d;
    logic [W-1:0]  shift_q, shift_d;
    logic [2:0]    residue_q, residue_d;
    logic [CW-1:0] count_q, count_d;
    logic          res_id_q, res_id_d;

    logic          grant_valid;
    logic          grant_id;
    logic [W-1:0]  grant_data;
    logic          accept;
    logic [3:0]    res_step;
    logic [2:0]    res_next;

    // rr_q names the favoured requester; fall back to the other one.
    always_comb begin
        grant_valid = bus.req0_valid | bus.req1_valid;
        if (rr_q) begin
            grant_id = bus.req1_valid ? 1'b1 : 1'b0;
        end else begin
            grant_id = bus.req0_valid ? 1'b0 : 1'b1;
        end
        grant_data = grant_id ? bus.req1_data : bus.req0_data;
    end

    assign accept         = (state_q == IDLE) & grant_valid & ~clr;
    assign bus.req0_ready = accept & (grant_id == 1'b0);
    assign bus.req1_ready = accept & (grant_id == 1'b1);

    // 2*r + bit is at most 9, so one conditional subtract keeps it in 0..4.
    always_comb begin
        res_step = {residue_q, 1'b0} + {3'b000, shift_q[W-1]};
        res_next = (res_step >= 4'd5) ? 3'(res_step - 4'd5) : 3'(res_step);
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        shift_d   = shift_q;
        residue_d = residue_q;
        count_d   = count_q;
        res_id_d  = res_id_q;
        if (clr) begin
            state_d   = IDLE;
            residue_d = '0;
            count_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shift_d   = grant_data;
                        residue_d = '0;
                        count_d   = CW'(W);
                        res_id_d  = grant_id;
                        rr_d      = ~grant_id;
                        state_d   = SHIFT;
                    end
                end
                SHIFT: begin
                    residue_d = res_next;
                    shift_d   = shift_q << 1;
                    count_d   = count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_q      <= 1'b0;
            shift_q   <= '0;
            residue_q <= '0;
            count_q   <= '0;
            res_id_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            shift_q   <= shift_d;
            residue_q <= residue_d;
            count_q   <= count_d;
            res_id_q  <= res_id_d;
        end
    end

    // res_div is qualified by DONE so it reads 0 out of reset and while idle.
    assign bus.res_valid   = (state_q == DONE);
    assign bus.res_id      = res_id_q;
    assign bus.res_residue = residue_q;
    assign bus.res_div     = (state_q == DONE) & (residue_q == 3'd0);
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_mod5_stream_sched.sv
module tb_mod5_stream_sched;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clr = 1'b0;
   logic busy;
   int   n_cmp = 0;
   int   n_err = 0;

   mod5_stream_sched_if #(.W(8)) bus();

   mod5_stream_sched #(.W(8)) dut (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .bus  (bus),
      .busy (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input int id, input logic [7:0] d);
      int t;
      if (id == 0) begin
         bus.req0_valid = 1'b1;
         bus.req0_data  = d;
      end else begin
         bus.req1_valid = 1'b1;
         bus.req1_data  = d;
      end
      #1;
      t = 0;
      while (!(id == 0 ? bus.req0_ready : bus.req1_ready) && t < 20) begin
         tick();
         t++;
      end
      chk("accept_ready", (id == 0 ? bus.req0_ready : bus.req1_ready), 1'b1);
      tick();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
   endtask

   task automatic wait_result();
      int t;
      t = 0;
      while (!bus.res_valid && t < 30) begin
         tick();
         t++;
      end
      chk("res_wait", bus.res_valid, 1'b1);
   endtask

   task automatic run_word(input int id, input logic [7:0] d, input logic [2:0] exp_res);
      accept(id, d);
      wait_result();
      chk("word_id", bus.res_id, id[0]);
      chk("word_residue", bus.res_residue, exp_res);
      chk("word_div", bus.res_div, (exp_res == 3'd0));
      tick();
      chk("word_idle", busy, 1'b0);
   endtask

   initial begin
      logic exp_id;
      int   t;

      bus.req0_valid = 1'b0;
      bus.req0_data  = '0;
      bus.req1_valid = 1'b0;
      bus.req1_data  = '0;
      bus.res_ready  = 1'b0;

      #12;
      chk("rst_busy", busy, 1'b0);
      chk("rst_res_valid", bus.res_valid, 1'b0);
      chk("rst_res_id", bus.res_id, 1'b0);
      chk("rst_residue", bus.res_residue, 3'd0);
      chk("rst_div", bus.res_div, 1'b0);
      chk("rst_ready0", bus.req0_ready, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      bus.req0_valid = 1'b1;
      bus.req0_data  = 8'h0A;
      bus.res_ready  = 1'b1;
      #1;
      chk("lat_ready0", bus.req0_ready, 1'b1);
      chk("lat_ready1", bus.req1_ready, 1'b0);
      tick();
      bus.req0_valid = 1'b0;
      chk("lat_busy", busy, 1'b1);
      repeat (7) tick();
      chk("lat_not_yet", bus.res_valid, 1'b0);
      tick();
      chk("lat_valid", bus.res_valid, 1'b1);
      chk("lat_id", bus.res_id, 1'b0);
      chk("lat_residue", bus.res_residue, 3'd0);
      chk("lat_div", bus.res_div, 1'b1);
      tick();
      chk("lat_idle", busy, 1'b0);
      chk("lat_drop", bus.res_valid, 1'b0);

      run_word(1, 8'h07, 3'd2);
      run_word(1, 8'hFF, 3'd0);
      run_word(1, 8'h01, 3'd1);

      bus.req0_valid = 1'b1;
      bus.req0_data  = 8'h2A;
      bus.req1_valid = 1'b1;
      bus.req1_data  = 8'h63;
      for (int i = 0; i < 4; i++) begin
         #1;
         t = 0;
         while (!(bus.req0_ready | bus.req1_ready) && t < 20) begin
            tick();
            t++;
         end
         exp_id = (i % 2 == 1);
         chk("alt_one_ready", (bus.req0_ready & bus.req1_ready), 1'b0);
         chk("alt_grant", bus.req1_ready, exp_id);
         tick();
         wait_result();
         chk("alt_id", bus.res_id, exp_id);
         chk("alt_residue", bus.res_residue, (exp_id ? 3'd4 : 3'd2));
         tick();
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;

      bus.res_ready = 1'b0;
      accept(0, 8'h11);
      wait_result();
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk("hold_valid", bus.res_valid, 1'b1);
         chk("hold_residue", bus.res_residue, 3'd2);
         chk("hold_id", bus.res_id, 1'b0);
         chk("hold_no_ready", (bus.req0_ready | bus.req1_ready), 1'b0);
         tick();
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.res_ready  = 1'b1;
      tick();
      chk("hold_release_valid", bus.res_valid, 1'b0);
      chk("hold_release_busy", busy, 1'b0);

      accept(0, 8'h80);
      tick();
      tick();
      tick();
      #2;
      rst = 1'b1;
      #1;
      chk("arst_busy", busy, 1'b0);
      chk("arst_valid", bus.res_valid, 1'b0);
      chk("arst_residue", bus.res_residue, 3'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (12) tick();
      chk("arst_no_result", bus.res_valid, 1'b0);
      chk("arst_idle", busy, 1'b0);
      bus.req0_valid = 1'b1;
      bus.req0_data  = 8'h80;
      bus.req1_valid = 1'b1;
      bus.req1_data  = 8'h07;
      #1;
      chk("arst_prio0", bus.req0_ready, 1'b1);
      chk("arst_prio1", bus.req1_ready, 1'b0);
      tick();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      wait_result();
      chk("arst_word_residue", bus.res_residue, 3'd3);
      chk("arst_word_id", bus.res_id, 1'b0);
      tick();

      bus.res_ready = 1'b0;
      accept(1, 8'h07);
      wait_result();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_done_valid", bus.res_valid, 1'b0);
      chk("clr_done_busy", busy, 1'b0);
      chk("clr_done_div", bus.res_div, 1'b0);
      bus.req0_valid = 1'b1;
      bus.req0_data  = 8'h63;
      bus.req1_valid = 1'b1;
      bus.req1_data  = 8'hFF;
      #1;
      chk("clr_done_next0", bus.req0_ready, 1'b1);
      chk("clr_done_next1", bus.req1_ready, 1'b0);
      tick();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;

      tick();
      tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_shift_valid", bus.res_valid, 1'b0);
      chk("clr_shift_busy", busy, 1'b0);
      repeat (10) tick();
      chk("clr_shift_no_result", bus.res_valid, 1'b0);
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      clr = 1'b1;
      #1;
      chk("clr_blocks_ready", (bus.req0_ready | bus.req1_ready), 1'b0);
      clr = 1'b0;
      #1;
      chk("clr_shift_next1", bus.req1_ready, 1'b1);
      chk("clr_shift_next0", bus.req0_ready, 1'b0);
      tick();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      wait_result();
      chk("clr_word_id", bus.res_id, 1'b1);
      chk("clr_word_residue", bus.res_residue, 3'd0);
      chk("clr_word_div", bus.res_div, 1'b1);
      bus.res_ready = 1'b1;
      tick();
      chk("final_idle", busy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
